gzip_stream_arbiter: RTL

- Shares one gzip compressor pipeline among N_REQ independent AXI4-Stream requesters.
- Arbitration is packet-granular: a grant holds from first beat to tlast.
- Granted requester IDs are queued in an internal tag FIFO; compressed output packets are steered back to the matching requester in order, since the compressor is in-order.
- Sits between the per-requester input streams and the compressor wrapper input/output.

---
 rtl/gzip_stream_arbiter_pkg.sv | 22 ++
 rtl/gzip_tag_fifo.sv | 66 ++++++
 rtl/gzip_stream_arbiter.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/gzip_stream_arbiter_pkg.sv
// rtl/gzip_stream_arbiter_pkg.sv - shared types and constants for the gzip stream arbiter
//
// Contents:
//   GZIP_MAX_OUTSTANDING  default depth of the tag FIFO (packets in flight in the compressor)
//   GZIP_N_REQ            default requester count
//   req_id_t              requester / tag ID for the default requester count
//   arb_state_t           input arbiter states
package gzip_stream_arbiter_pkg;

  localparam int GZIP_MAX_OUTSTANDING = 8;
  localparam int GZIP_N_REQ           = 4;

  // Sized for the default requester count; the top derives its own ID type
  // from N_REQ and hands it to the tag FIFO, so other counts stay exact.
  typedef logic [$clog2(GZIP_N_REQ)-1:0] req_id_t;

  typedef enum logic {
    ARB_IDLE,
    ARB_GRANT
  } arb_state_t;

endpackage

// File: rtl/gzip_tag_fifo.sv
// rtl/gzip_tag_fifo.sv - synchronous FIFO of requester IDs in compressor order
//
// Ports:
//   clk, rst_n   clock, synchronous active-low reset (empties the FIFO)
//   push, din    enqueue din; ignored while full
//   pop          dequeue the head; ignored while empty
//   head         oldest queued ID (stale when empty)
//   full, empty  occupancy flags, derived from the registered count
//   count        current occupancy, 0..DEPTH
module gzip_tag_fifo
  import gzip_stream_arbiter_pkg::*;
#(
  parameter int  DEPTH = GZIP_MAX_OUTSTANDING,
  parameter type T     = req_id_t
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  T                           din,
  input  logic                       pop,
  output T                           head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  T              mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage needs no reset: nothing is read until the count says it was written.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/gzip_stream_arbiter.sv
// rtl/gzip_stream_arbiter.sv - packet-granular round-robin front end for a shared gzip compressor
//
// Ports:
//   clk, rst_n                        clock, synchronous active-low reset
//   s_tdata/tkeep/tlast/tvalid/tready requester input streams, requester i at slice i
//   c_in_*                            single stream into the compressor
//   c_out_*                           compressed stream back from the compressor
//   m_tdata/tkeep/tlast/tvalid/tready per-requester output streams (data/keep broadcast)
//   outstanding                       packets granted but not yet fully returned
//   err_orphan                        sticky: compressor output seen with no tag queued
module gzip_stream_arbiter
  import gzip_stream_arbiter_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int DATA_BITS = 512,
  parameter int TAG_DEPTH = GZIP_MAX_OUTSTANDING
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [N_REQ*DATA_BITS-1:0]     s_tdata,
  input  logic [N_REQ*DATA_BITS/8-1:0]   s_tkeep,
  input  logic [N_REQ-1:0]               s_tlast,
  input  logic [N_REQ-1:0]               s_tvalid,
  output logic [N_REQ-1:0]               s_tready,
  output logic [DATA_BITS-1:0]           c_in_tdata,
  output logic [DATA_BITS/8-1:0]         c_in_tkeep,
  output logic                           c_in_tlast,
  output logic                           c_in_tvalid,
  input  logic                           c_in_tready,
  input  logic [DATA_BITS-1:0]           c_out_tdata,
  input  logic [DATA_BITS/8-1:0]         c_out_tkeep,
  input  logic                           c_out_tlast,
  input  logic                           c_out_tvalid,
  output logic                           c_out_tready,
  output logic [N_REQ*DATA_BITS-1:0]     m_tdata,
  output logic [N_REQ*DATA_BITS/8-1:0]   m_tkeep,
  output logic [N_REQ-1:0]               m_tlast,
  output logic [N_REQ-1:0]               m_tvalid,
  input  logic [N_REQ-1:0]               m_tready,
  output logic [$clog2(TAG_DEPTH+1)-1:0] outstanding,
  output logic                           err_orphan
);

  localparam int IDW = $clog2(N_REQ);
  localparam int KB  = DATA_BITS / 8;

  typedef logic [IDW-1:0] id_t;

  arb_state_t state, state_nxt;
  id_t        rr_ptr;
  id_t        grant;
  id_t        sel;
  id_t        head;
  logic       found;
  logic       push;
  logic       pop;
  logic       fifo_full;
  logic       fifo_empty;

  // First valid requester scanning rr_ptr, rr_ptr+1, ... wrapping at N_REQ.
  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    sel   = rr_ptr;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && s_tvalid[id_t'(idx)]) begin
        found = 1'b1;
        sel   = id_t'(idx);
      end
    end
  end

  // Granting costs the one IDLE cycle; the tag is queued at the same moment
  // so the compressor's in-order output always finds its owner.
  assign push = (state == ARB_IDLE) && found && !fifo_full;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ARB_IDLE;
      rr_ptr <= '0;
      grant  <= '0;
    end else begin
      state <= state_nxt;
      if (push) begin
        grant  <= sel;
        rr_ptr <= (sel == id_t'(N_REQ-1)) ? '0 : sel + 1'b1;
      end
    end
  end

  // In GRANT the selected requester is wired straight through, so data beats
  // see no added latency.
  always_comb begin
    state_nxt   = state;
    s_tready    = '0;
    c_in_tdata  = '0;
    c_in_tkeep  = '0;
    c_in_tlast  = 1'b0;
    c_in_tvalid = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (push) state_nxt = ARB_GRANT;
      end
      ARB_GRANT: begin
        for (int i = 0; i < N_REQ; i++) begin
          if (id_t'(i) == grant) begin
            c_in_tdata  = s_tdata[i*DATA_BITS +: DATA_BITS];
            c_in_tkeep  = s_tkeep[i*KB +: KB];
            c_in_tlast  = s_tlast[i];
            c_in_tvalid = s_tvalid[i];
            s_tready[i] = c_in_tready;
          end
        end
        if (c_in_tvalid && c_in_tready && c_in_tlast) state_nxt = ARB_IDLE;
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  // Return path: only the requester named by the oldest tag sees the stream.
  // With no tag queued the compressor is held off rather than dropped.
  assign m_tdata = {N_REQ{c_out_tdata}};
  assign m_tkeep = {N_REQ{c_out_tkeep}};

  always_comb begin
    m_tvalid     = '0;
    m_tlast      = '0;
    c_out_tready = 1'b0;
    if (!fifo_empty) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (id_t'(i) == head) begin
          m_tvalid[i]  = c_out_tvalid;
          m_tlast[i]   = c_out_tlast;
          c_out_tready = m_tready[i];
        end
      end
    end
  end

  assign pop = c_out_tvalid && c_out_tready && c_out_tlast;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_orphan <= 1'b0;
    end else if (c_out_tvalid && fifo_empty) begin
      err_orphan <= 1'b1;
    end
  end

  gzip_tag_fifo #(
    .DEPTH (TAG_DEPTH),
    .T     (id_t)
  ) u_tag_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (sel),
    .pop   (pop),
    .head  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (outstanding)
  );

endmodule
